cma_host_master: RTL

CMA_HOST_MASTER -- requirements
Module: cma_host_master

---
 rtl/cma_host_master.sv | 165 ++++++++++++++++
 1 files changed

// File: rtl/cma_host_master.sv
// Host-side command master for a CMA: turns host commands into single-cycle
// CMA write/read pulses, run/done handshakes, and config register updates,
// and returns read data or run cycle counts through a valid/ready response.
module cma_host_master #(
   parameter int unsigned DATA_W  = 24,
   parameter int unsigned ADR_W   = 12,
   parameter int unsigned ROMUL_W = 4,
   parameter int unsigned TMO_W   = 20
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                cmd_valid,
   output logic                cmd_ready,
   input  logic [2:0]          cmd_op,
   input  logic [ADR_W-1:0]    cmd_adr,
   input  logic [DATA_W-1:0]   cmd_data,
   output logic                rsp_valid,
   input  logic                rsp_ready,
   output logic [DATA_W-1:0]   rsp_data,
   output logic                rsp_err,
   output logic                exwe,
   output logic                exre,
   output logic [ADR_W-1:0]    exa,
   output logic [DATA_W-1:0]   exwd,
   input  logic [DATA_W-1:0]   exrd,
   output logic [ROMUL_W-1:0]  exromul,
   output logic                cbank,
   output logic                run,
   input  logic                done,
   output logic                busy
);

   localparam int unsigned OP_W = 3;
   localparam logic [OP_W-1:0] OP_WRITE = 3'd1;
   localparam logic [OP_W-1:0] OP_READ  = 3'd2;
   localparam logic [OP_W-1:0] OP_RUN   = 3'd3;
   localparam logic [OP_W-1:0] OP_CBANK = 3'd4;
   localparam logic [OP_W-1:0] OP_ROMUL = 3'd5;
   localparam logic [TMO_W-1:0] CNT_MAX = '1;

   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      RD_WAIT = 3'd1,
      RUN_P   = 3'd2,
      RUN_W   = 3'd3,
      RSP     = 3'd4
   } state_t;

   state_t               state_q;
   logic                 rsp_valid_q;
   logic [DATA_W-1:0]    rsp_data_q;
   logic                 rsp_err_q;
   logic                 exwe_q;
   logic                 exre_q;
   logic [ADR_W-1:0]     exa_q;
   logic [DATA_W-1:0]    exwd_q;
   logic [ROMUL_W-1:0]   exromul_q;
   logic                 cbank_q;
   logic                 run_q;
   logic [TMO_W-1:0]     cnt_q;
   logic [TMO_W-1:0]     cnt_d;
   logic                 cmd_fire_c;

   // Accept only when idle with no response outstanding; never while in reset.
   assign cmd_ready  = (state_q == IDLE) && !rsp_valid_q && !rst;
   assign cmd_fire_c = cmd_valid && cmd_ready;
   assign cnt_d      = cnt_q + TMO_W'(1);

   assign rsp_valid = rsp_valid_q;
   assign rsp_data  = rsp_data_q;
   assign rsp_err   = rsp_err_q;
   assign exwe      = exwe_q;
   assign exre      = exre_q;
   assign exa       = exa_q;
   assign exwd      = exwd_q;
   assign exromul   = exromul_q;
   assign cbank     = cbank_q;
   assign run       = run_q;
   assign busy      = (state_q != IDLE);

   // Command FSM, CMA strobes, config registers and response capture.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= IDLE;
         rsp_valid_q <= 1'b0;
         rsp_data_q  <= '0;
         rsp_err_q   <= 1'b0;
         exwe_q      <= 1'b0;
         exre_q      <= 1'b0;
         exa_q       <= '0;
         exwd_q      <= '0;
         exromul_q   <= '0;
         cbank_q     <= 1'b0;
         run_q       <= 1'b0;
         cnt_q       <= '0;
      end else begin
         // Strobes default low so every pulse is exactly one cycle wide.
         exwe_q <= 1'b0;
         exre_q <= 1'b0;
         run_q  <= 1'b0;
         case (state_q)
            IDLE: begin
               if (cmd_fire_c) begin
                  case (cmd_op)
                     OP_WRITE: begin
                        exwe_q <= 1'b1;
                        exa_q  <= cmd_adr;
                        exwd_q <= cmd_data;
                     end
                     OP_READ: begin
                        exre_q  <= 1'b1;
                        exa_q   <= cmd_adr;
                        state_q <= RD_WAIT;
                     end
                     OP_RUN: begin
                        run_q   <= 1'b1;
                        cnt_q   <= '0;
                        state_q <= RUN_P;
                     end
                     OP_CBANK: cbank_q   <= cmd_data[0];
                     OP_ROMUL: exromul_q <= cmd_data[ROMUL_W-1:0];
                     default: ;
                  endcase
               end
            end
            RD_WAIT: begin
               // First RD_WAIT cycle is the exre cycle; exrd is valid the cycle after.
               if (!exre_q) begin
                  rsp_data_q  <= exrd;
                  rsp_err_q   <= 1'b0;
                  rsp_valid_q <= 1'b1;
                  state_q     <= RSP;
               end
            end
            RUN_P: begin
               // done is deliberately not sampled here: it may be stale from the last job.
               state_q <= RUN_W;
            end
            RUN_W: begin
               if (done) begin
                  rsp_data_q  <= DATA_W'(cnt_q);
                  rsp_err_q   <= 1'b0;
                  rsp_valid_q <= 1'b1;
                  state_q     <= RSP;
               end else if (cnt_q == CNT_MAX) begin
                  rsp_data_q  <= DATA_W'(CNT_MAX);
                  rsp_err_q   <= 1'b1;
                  rsp_valid_q <= 1'b1;
                  state_q     <= RSP;
               end else begin
                  cnt_q <= cnt_d;
               end
            end
            RSP: begin
               if (rsp_ready) begin
                  rsp_valid_q <= 1'b0;
                  state_q     <= IDLE;
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

endmodule
